// File: rtl/seg7_to_ascii_rx_if.sv
// Handshake bundle for the 7-segment-to-ASCII receiver.
// The slave modport is the receiver. The master modport is the producer/consumer side.
interface seg7_to_ascii_rx_if #(
    parameter int DEPTH = 4
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic [6:0]    SegIn;
    logic          SegValid;
    logic          SegReady;
    logic          AlphaPref;
    logic [7:0]    AsciiOut;
    logic          AsciiValid;
    logic          AsciiReady;
    logic          DecodeErr;
    logic [LW-1:0] Level;
    logic [15:0]   CharCount;
    logic [7:0]    ErrCount;

    modport master (
        output SegIn, SegValid, AlphaPref, AsciiReady,
        input  SegReady, AsciiOut, AsciiValid, DecodeErr, Level, CharCount, ErrCount
    );

    modport slave (
        input  SegIn, SegValid, AlphaPref, AsciiReady,
        output SegReady, AsciiOut, AsciiValid, DecodeErr, Level, CharCount, ErrCount
    );
endinterface

// File: rtl/seg7_to_ascii_rx.sv
// seg7_to_ascii_rx: decodes active-low 7-segment patterns back to uppercase
// ASCII, buffers them in a DEPTH-entry FIFO and keeps accept/error counters.
// Unknown patterns are stored as '?', pulse DecodeErr and bump ErrCount.
module seg7_to_ascii_rx #(
    parameter int DEPTH = 4
) (
    input logic               clk,
    input logic               reset,
    seg7_to_ascii_rx_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
    localparam logic [7:0]    ERR_CHAR = 8'h3F;

    // Pattern to {err, ascii}; ambiguous shapes follow the alpha preference.
    function automatic logic [8:0] seg_decode(input logic [6:0] seg, input logic alpha);
        logic [7:0] ch;
        logic       err;
        ch  = ERR_CHAR;
        err = 1'b0;
        case (seg)
            7'h40: ch = alpha ? "O" : "0";
            7'h79: ch = "1";
            7'h24: ch = alpha ? "Z" : "2";
            7'h30: ch = "3";
            7'h19: ch = "4";
            7'h12: ch = alpha ? "S" : "5";
            7'h02: ch = "6";
            7'h78: ch = "7";
            7'h00: ch = "8";
            7'h10: ch = alpha ? "G" : "9";
            7'h08: ch = "A";
            7'h03: ch = "B";
            7'h46: ch = "C";
            7'h21: ch = "D";
            7'h06: ch = "E";
            7'h0E: ch = "F";
            7'h0B: ch = "H";
            7'h4F: ch = "I";
            7'h61: ch = "J";
            // The encoder shares this shape between K and X; only K comes back.
            7'h09: ch = "K";
            7'h47: ch = "L";
            7'h6A: ch = "M";
            7'h2A: ch = "N";
            7'h0C: ch = "P";
            7'h18: ch = "Q";
            7'h2F: ch = "R";
            7'h07: ch = "T";
            7'h41: ch = "U";
            7'h63: ch = "V";
            7'h55: ch = "W";
            7'h11: ch = "Y";
            7'h7D: ch = 8'h27;
            7'h7F: ch = 8'h20;
            default: begin
                ch  = ERR_CHAR;
                err = 1'b1;
            end
        endcase
        return {err, ch};
    endfunction

    // Saturating increment for the error counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [LW-1:0] level;
    logic [15:0]   char_cnt;
    logic [7:0]    err_cnt;
    logic          dec_err_p1;

    logic          seg_ready;
    logic          vld_p0;
    logic          pop;
    logic [8:0]    dec_p0;

    // Handshake qualification and decode of the pattern on the input bus.
    always_comb begin
        seg_ready = 1'b0;
        vld_p0    = 1'b0;
        pop       = 1'b0;
        dec_p0    = seg_decode(bus.SegIn, bus.AlphaPref);
        // A full FIFO refuses input even when a pop happens in the same cycle.
        seg_ready = !reset && (level < FULL_LVL);
        vld_p0    = bus.SegValid && seg_ready;
        pop       = !reset && (level != '0) && bus.AsciiReady;
    end

    // ---- stage p0 -> p1: decoded character lands in the FIFO ----

    // FIFO storage; data is not reset, only the pointers/level qualify it.
    always_ff @(posedge clk) begin
        if (vld_p0) begin
            mem[wptr] <= dec_p0[7:0];
        end
    end

    // Pointers and occupancy; push and pop may occur together.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (vld_p0) begin
                wptr <= wptr + AW'(1);
            end
            if (pop) begin
                rptr <= rptr + AW'(1);
            end
            case ({vld_p0, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // Accept/error counters and the one-cycle error pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            char_cnt   <= '0;
            err_cnt    <= '0;
            dec_err_p1 <= 1'b0;
        end else begin
            dec_err_p1 <= vld_p0 && dec_p0[8];
            if (vld_p0) begin
                char_cnt <= char_cnt + 16'd1;
                if (dec_p0[8]) begin
                    err_cnt <= sat_inc8(err_cnt);
                end
            end
        end
    end

    assign bus.SegReady   = seg_ready;
    assign bus.AsciiValid = (level != '0);
    assign bus.AsciiOut   = (level != '0) ? mem[rptr] : 8'h00;
    assign bus.DecodeErr  = dec_err_p1;
    assign bus.Level      = level;
    assign bus.CharCount  = char_cnt;
    assign bus.ErrCount   = err_cnt;
endmodule
